// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, decipher FSM encodings and GF(2^8) helpers.
// Used by aes_decipher_block. No ports.
package aes_pkg;

  localparam logic       AES_128_BIT_KEY = 1'b0;
  localparam logic       AES_256_BIT_KEY = 1'b1;
  localparam logic [3:0] AES128_ROUNDS   = 4'ha;
  localparam logic [3:0] AES256_ROUNDS   = 4'he;

  typedef enum logic [1:0] {
    DEC_IDLE = 2'd0,
    DEC_INIT = 2'd1,
    DEC_SBOX = 2'd2,
    DEC_MAIN = 2'd3
  } dec_state_e;

  // xtime: multiply by x modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gm2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm9(input logic [7:0] b);
    return gm2(gm2(gm2(b))) ^ b;
  endfunction

  function automatic logic [7:0] gm11(input logic [7:0] b);
    return gm2(gm2(gm2(b))) ^ gm2(b) ^ b;
  endfunction

  function automatic logic [7:0] gm13(input logic [7:0] b);
    return gm2(gm2(gm2(b))) ^ gm2(gm2(b)) ^ b;
  endfunction

  function automatic logic [7:0] gm14(input logic [7:0] b);
    return gm2(gm2(gm2(b))) ^ gm2(gm2(b)) ^ gm2(b);
  endfunction

  // InvMixColumns on one column; byte 0 (row 0) is the MSB.
  function automatic logic [31:0] inv_mix_word(input logic [31:0] w);
    logic [7:0] b0, b1, b2, b3;
    b0 = w[31:24]; b1 = w[23:16]; b2 = w[15:8]; b3 = w[7:0];
    return {gm14(b0) ^ gm11(b1) ^ gm13(b2) ^ gm9(b3),
            gm9(b0)  ^ gm14(b1) ^ gm11(b2) ^ gm13(b3),
            gm13(b0) ^ gm9(b1)  ^ gm14(b2) ^ gm11(b3),
            gm11(b0) ^ gm13(b1) ^ gm9(b2)  ^ gm14(b3)};
  endfunction

  // InvShiftRows: row r of column c takes row r of column (c - r) mod 4.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [31:0] c0, c1, c2, c3;
    c0 = s[127:96]; c1 = s[95:64]; c2 = s[63:32]; c3 = s[31:0];
    return {c0[31:24], c3[23:16], c2[15:8], c1[7:0],
            c1[31:24], c0[23:16], c3[15:8], c2[7:0],
            c2[31:24], c1[23:16], c0[15:8], c3[7:0],
            c3[31:24], c2[23:16], c1[15:8], c0[7:0]};
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// aes_inv_sbox: combinational inverse S-box over a 32-bit word (four byte lookups).
// Ports:
//   word     - in  32: input word
//   sub_word - out 32: InvSubWord(word)
module aes_inv_sbox (
  input  logic [31:0] word,
  output logic [31:0] sub_word
);

  // Table packed MSB-first: entry b sits at bits [(255-b)*8 +: 8].
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sb(input logic [7:0] b);
    return INV_SBOX[{~b, 3'b000} +: 8];
  endfunction

  assign sub_word = {inv_sb(word[31:24]), inv_sb(word[23:16]),
                     inv_sb(word[15:8]),  inv_sb(word[7:0])};

endmodule

// File: rtl/aes_decipher_block.sv
// aes_decipher_block: iterative AES inverse cipher (AES-128 / AES-256).
// Round keys are fetched by index from an external key memory.
// Optional macro AES_DECIPHER_PARALLEL_SBOX_EN: four inverse S-box instances,
// one-cycle InvSubBytes. Default: one instance, word-serial over four cycles.
// Ports:
//   clk       - in   1: clock
//   reset     - in   1: synchronous active-high reset
//   next      - in   1: start pulse, accepted only when idle
//   keylen    - in   1: 0 = AES-128, 1 = AES-256 (sampled on accept)
//   round     - out  4: round-key index for the key memory
//   round_key - in 128: round key for 'round' (same cycle)
//   block     - in 128: ciphertext (sampled on accept)
//   new_block - out 128: working state / plaintext when ready
//   ready     - out  1: idle, result valid
module aes_decipher_block
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         next,
  input  logic         keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

  logic [31:0] block_w0, block_w1, block_w2, block_w3;
  logic        keylen_reg;
  logic [3:0]  round_ctr;
  logic [1:0]  sword_ctr;
  logic        ready_reg;
  dec_state_e  dec_state;

  logic [127:0]      state_vec, init_vec, main_vec;
  logic [3:0][31:0]  cur_w, blk_w, init_w, fin_w, mix_w, w_new;
  logic [3:0]        w_we;

  assign state_vec = {block_w0, block_w1, block_w2, block_w3};
  assign init_vec  = state_vec ^ round_key;
  assign main_vec  = inv_shift_rows(state_vec) ^ round_key;

  // Index i of every word array is column i (column 0 = bits 127:96).
  for (genvar i = 0; i < 4; i++) begin : g_words
    assign cur_w[i]  = state_vec[127-32*i -: 32];
    assign blk_w[i]  = block[127-32*i -: 32];
    assign init_w[i] = init_vec[127-32*i -: 32];
    assign fin_w[i]  = main_vec[127-32*i -: 32];
    assign mix_w[i]  = inv_mix_word(main_vec[127-32*i -: 32]);
  end

`ifdef AES_DECIPHER_PARALLEL_SBOX_EN
  logic [3:0][31:0] sub_w;
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_inv_sbox u_sbox (.word(cur_w[i]), .sub_word(sub_w[i]));
  end
`else
  logic [31:0] sel_w, sub_w1;
  assign sel_w = cur_w[sword_ctr];
  aes_inv_sbox u_sbox (.word(sel_w), .sub_word(sub_w1));
`endif

  // Word update select. InvSubBytes runs ahead of InvShiftRows; both are
  // bytewise so the order does not change the result.
  always_comb begin
    w_we  = 4'h0;
    w_new = cur_w;
    case (dec_state)
      DEC_IDLE: if (next) begin
        w_we  = 4'hf;
        w_new = blk_w;
      end
      DEC_INIT: begin
        w_we  = 4'hf;
        w_new = init_w;
      end
      DEC_SBOX: begin
`ifdef AES_DECIPHER_PARALLEL_SBOX_EN
        w_we  = 4'hf;
        w_new = sub_w;
`else
        w_we[sword_ctr]  = 1'b1;
        w_new[sword_ctr] = sub_w1;
`endif
      end
      DEC_MAIN: begin
        w_we  = 4'hf;
        // Final round (key index 0) skips InvMixColumns.
        w_new = (round_ctr == 4'd0) ? fin_w : mix_w;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      block_w0 <= '0;
      block_w1 <= '0;
      block_w2 <= '0;
      block_w3 <= '0;
    end else begin
      if (w_we[0]) block_w0 <= w_new[0];
      if (w_we[1]) block_w1 <= w_new[1];
      if (w_we[2]) block_w2 <= w_new[2];
      if (w_we[3]) block_w3 <= w_new[3];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dec_state  <= DEC_IDLE;
      keylen_reg <= AES_128_BIT_KEY;
      round_ctr  <= 4'd0;
      sword_ctr  <= 2'd0;
      ready_reg  <= 1'b1;
    end else begin
      case (dec_state)
        DEC_IDLE: if (next) begin
          keylen_reg <= keylen;
          round_ctr  <= keylen ? AES256_ROUNDS : AES128_ROUNDS;
          ready_reg  <= 1'b0;
          dec_state  <= DEC_INIT;
        end
        DEC_INIT: begin
          // Round index steps to Nr-1 as soon as key Nr has been applied.
          round_ctr <= (keylen_reg ? AES256_ROUNDS : AES128_ROUNDS) - 4'd1;
          sword_ctr <= 2'd0;
          dec_state <= DEC_SBOX;
        end
        DEC_SBOX: begin
`ifdef AES_DECIPHER_PARALLEL_SBOX_EN
          dec_state <= DEC_MAIN;
`else
          sword_ctr <= sword_ctr + 2'd1;
          if (sword_ctr == 2'd3) dec_state <= DEC_MAIN;
`endif
        end
        DEC_MAIN: begin
          if (round_ctr != 4'd0) begin
            round_ctr <= round_ctr - 4'd1;
            dec_state <= DEC_SBOX;
          end else begin
            ready_reg <= 1'b1;
            dec_state <= DEC_IDLE;
          end
        end
        default: dec_state <= DEC_IDLE;
      endcase
    end
  end

  assign round     = round_ctr;
  assign ready     = ready_reg;
  assign new_block = state_vec;

endmodule
